// File: rtl/comb_lock_fsm_pkg.sv
// Shared types and default constants for the sequential combination lock.
package lock_pkg;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        FAIL    = 2'd2,
        LOCKOUT = 2'd3
    } lock_state_t;

    localparam int unsigned DEF_NUM_DIGITS     = 3;
    localparam int unsigned DEF_DIGIT_W        = 4;
    localparam int unsigned DEF_MAX_ATTEMPTS   = 3;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 500;
    localparam logic [11:0] DEF_RESET_COMB     = 12'ha15;

    // Width of a digit index; a single-digit lock still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comb_lock_fsm_if.sv
// Keypad-side and status-side signals of the combination lock.
interface comb_lock_fsm_if
    import lock_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int unsigned DIGIT_W      = DEF_DIGIT_W,
    parameter int unsigned MAX_ATTEMPTS = DEF_MAX_ATTEMPTS
);
    localparam int unsigned COMB_W = NUM_DIGITS * DIGIT_W;
    localparam int unsigned IDX_W  = idx_width(NUM_DIGITS);
    localparam int unsigned ATT_W  = $clog2(MAX_ATTEMPTS + 1);

    logic               key_valid;
    logic [DIGIT_W-1:0] key_digit;
    logic               clear;
    logic               load_comb;
    logic [COMB_W-1:0]  comb_in;
    logic               unlocked;
    logic               error;
    logic               locked_out;
    logic [IDX_W-1:0]   digit_idx;
    logic [ATT_W-1:0]   attempts_left;

    modport master (
        output key_valid, key_digit, clear, load_comb, comb_in,
        input  unlocked, error, locked_out, digit_idx, attempts_left
    );

    modport slave (
        input  key_valid, key_digit, clear, load_comb, comb_in,
        output unlocked, error, locked_out, digit_idx, attempts_left
    );

endinterface

// File: rtl/comb_lock_fsm_lockout_timer.sv
// Loadable down-counter that times the lockout period.
module lockout_timer
    import lock_pkg::*;
#(
    parameter int unsigned CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic hz100,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic busy,
    output logic done
);
    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] count_q;

    // Load takes priority; otherwise count down while enabled and non-zero.
    always_ff @(posedge hz100) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CNT_W'(CYCLES);
        end else if (count && busy) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // done marks the final counted cycle; the count reaches 0 on the next edge.
    assign busy = (count_q != '0);
    assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/comb_lock_fsm.sv
// Sequential combination-lock checker with attempt counting and timed lockout.
module comb_lock_fsm
    import lock_pkg::*;
#(
    parameter int unsigned NUM_DIGITS                     = DEF_NUM_DIGITS,
    parameter int unsigned DIGIT_W                        = DEF_DIGIT_W,
    parameter int unsigned MAX_ATTEMPTS                   = DEF_MAX_ATTEMPTS,
    parameter int unsigned LOCKOUT_CYCLES                 = DEF_LOCKOUT_CYCLES,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] RESET_COMB   = DEF_RESET_COMB
) (
    input  logic            hz100,
    input  logic            reset,
    comb_lock_fsm_if.slave  bus
);
    localparam int unsigned COMB_W = NUM_DIGITS * DIGIT_W;
    localparam int unsigned IDX_W  = idx_width(NUM_DIGITS);
    localparam int unsigned ATT_W  = $clog2(MAX_ATTEMPTS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_ATTEMPTS);

    lock_state_t        state_q, state_d;
    logic [COMB_W-1:0]  comb_q, comb_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mm_q, mm_d;
    logic [ATT_W-1:0]   att_q, att_d;
    logic               unlocked_q, error_q, locked_out_q;

    logic [DIGIT_W-1:0] cur_digit;
    logic               digit_miss;
    logic               timer_load, timer_busy, timer_done;

    // Stored digit the keypad is expected to match next.
    assign cur_digit = comb_q[32'(idx_q) * DIGIT_W +: DIGIT_W];

    assign timer_load = (state_q == FAIL) && (state_d == LOCKOUT);

    lockout_timer #(
        .CYCLES (LOCKOUT_CYCLES)
    ) u_timer (
        .hz100 (hz100),
        .reset (reset),
        .load  (timer_load),
        .count (state_q == LOCKOUT),
        .busy  (timer_busy),
        .done  (timer_done)
    );

    // State, combination, entry progress and attempt counter registers.
    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q      <= ENTRY;
            comb_q       <= RESET_COMB;
            idx_q        <= '0;
            mm_q         <= 1'b0;
            att_q        <= ATT_MAX;
            unlocked_q   <= 1'b0;
            error_q      <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            comb_q       <= comb_d;
            idx_q        <= idx_d;
            mm_q         <= mm_d;
            att_q        <= att_d;
            unlocked_q   <= (state_d == OPEN);
            error_q      <= (state_d == FAIL);
            locked_out_q <= (state_d == LOCKOUT);
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d    = state_q;
        comb_d     = comb_q;
        idx_d      = idx_q;
        mm_d       = mm_q;
        att_d      = att_q;
        digit_miss = 1'b0;

        unique case (state_q)
            ENTRY: begin
                if (bus.clear) begin
                    idx_d = '0;
                    mm_d  = 1'b0;
                end else if (bus.key_valid) begin
                    digit_miss = (bus.key_digit != cur_digit);
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        mm_d  = 1'b0;
                        if (mm_q || digit_miss) begin
                            state_d = FAIL;
                            if (att_q != '0) begin
                                att_d = att_q - ATT_W'(1);
                            end
                        end else begin
                            state_d = OPEN;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        mm_d  = mm_q | digit_miss;
                    end
                end
            end
            FAIL: begin
                state_d = (att_q == '0) ? LOCKOUT : ENTRY;
            end
            LOCKOUT: begin
                if (timer_done || !timer_busy) begin
                    state_d = ENTRY;
                    att_d   = ATT_MAX;
                end
            end
            OPEN: begin
                if (bus.load_comb) begin
                    comb_d = bus.comb_in;
                end
                if (bus.clear) begin
                    state_d = ENTRY;
                    att_d   = ATT_MAX;
                end
            end
            default: begin
                state_d = ENTRY;
            end
        endcase
    end

    assign bus.unlocked      = unlocked_q;
    assign bus.error         = error_q;
    assign bus.locked_out    = locked_out_q;
    assign bus.digit_idx     = idx_q;
    assign bus.attempts_left = att_q;

endmodule
